// File: rtl/cdc_hs_src_ctrl.sv
// Source side of a 4-phase req/ack CDC handshake: one pending word, tx_data held stable per transfer.
// Word accepted at edge N drives tx_req at edge N+1; in_ready low while the pending slot is full.
module cdc_hs_src_ctrl #(
  parameter int DATA_WIDTH = 66,
  parameter int NUM_STAGES = 2,
  parameter int TO_CYCLES  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  tx_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  ack_async,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clr_err,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  localparam int TW = $clog2(TO_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t                  state_q, state_d;
  logic [NUM_STAGES-1:0]   ack_chain;
  logic                    ack_sync;
  logic                    pend_valid;
  logic [DATA_WIDTH-1:0]   pend_data;
  logic [TW-1:0]           timer_q;
  logic                    load;
  logic                    done;
  logic                    accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[NUM_STAGES-2:0], ack_async};
    end
  end

  assign ack_sync = ack_chain[NUM_STAGES-1];
  assign in_ready = !pend_valid;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE) || pend_valid;

  // A stale ack seen in IDLE blocks the next request until the far side has released it.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid && !ack_sync) begin
          load    = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_sync) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      xfer_cnt   <= '0;
    end else begin
      state_q <= state_d;
      tx_req  <= (state_d == REQ_HI);
      if (load) begin
        tx_data <= pend_data;
      end
      // accept and load are exclusive: accept needs an empty slot, load a full one.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_data  <= in_data;
      end else if (load) begin
        pend_valid <= 1'b0;
      end
      if (done) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

  // Phase timer restarts on each state change and saturates; the handshake is never aborted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if ((state_q != IDLE) && (timer_q != TO_MAX)) begin
        timer_q <= timer_q + 1'b1;
      end
      if ((state_q != IDLE) && (timer_q == TO_MAX)) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
